reg_status_table: RTL and testbench

- Register status table and tag allocator for the dispatcher; sits at the far end of the free-tag list from the CDB.
- On dispatch of an instruction that writes a destination register, it pulls a free 6-bit tag from the free list and records the tag as that register's pending producer.
- It reports source-operand pending status and tags for the instruction being dispatched.
- On each CDB broadcast, it clears matching entries and returns the broadcast tag to the free list.

---
 rtl/reg_status_table.sv | 151 +++++++++++++++
 tb/tb_reg_status_table.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_table.sv
// rtl/reg_status_table.sv - register status table and tag allocator for the dispatcher
module reg_status_table #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 6,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic             disp_rd_we,
    input  logic [IDX_W-1:0] disp_rd,
    input  logic [IDX_W-1:0] disp_rs1,
    input  logic [IDX_W-1:0] disp_rs2,
    output logic             disp_ready,
    output logic             disp_done,
    output logic [TAG_W-1:0] disp_rd_tag,
    output logic             rs1_pend,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs2_pend,
    output logic [TAG_W-1:0] rs2_tag,
    output logic             tag_pull,
    input  logic [TAG_W-1:0] tag_from_fifo,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             tag_push,
    output logic [TAG_W-1:0] tag_to_fifo,
    output logic [TAG_W:0]   inflight_cnt,
    output logic             overflow_err
);

    localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(1 << TAG_W);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REGS-1:0] pend_q;
    logic [TAG_W-1:0]   tag_q [NUM_REGS];
    logic               tag_push_q;
    logic [TAG_W-1:0]   tag_to_fifo_q;
    logic [TAG_W:0]     inflight_q, inflight_d;
    logic               overflow_q;
    logic               need_tag;
    logic               alloc_done;

    assign need_tag   = disp_rd_we && (disp_rd != '0);
    assign alloc_done = (state_q == WAIT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state, handshake outputs and allocated tag
    always_comb begin
        state_d     = state_q;
        disp_ready  = 1'b0;
        disp_done   = 1'b0;
        tag_pull    = 1'b0;
        disp_rd_tag = '0;
        case (state_q)
            IDLE: begin
                disp_ready = !need_tag || !fifo_empty;
                if (disp_valid) begin
                    if (!need_tag) begin
                        disp_done = 1'b1;
                    end else if (!fifo_empty) begin
                        tag_pull = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                disp_done   = 1'b1;
                disp_rd_tag = tag_from_fifo;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // operand lookup against the pre-write table, with same-cycle CDB bypass
    always_comb begin
        rs1_pend = 1'b0;
        rs1_tag  = '0;
        rs2_pend = 1'b0;
        rs2_tag  = '0;
        if (disp_done) begin
            if (disp_rs1 != '0 && pend_q[disp_rs1] &&
                !(cdb_valid && cdb_tag == tag_q[disp_rs1])) begin
                rs1_pend = 1'b1;
                rs1_tag  = tag_q[disp_rs1];
            end
            if (disp_rs2 != '0 && pend_q[disp_rs2] &&
                !(cdb_valid && cdb_tag == tag_q[disp_rs2])) begin
                rs2_pend = 1'b1;
                rs2_tag  = tag_q[disp_rs2];
            end
        end
    end

    // table update: CDB clears first, dispatch write overrides on the same entry
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) tag_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (alloc_done && need_tag && disp_rd == IDX_W'(i)) begin
                    pend_q[i] <= 1'b1;
                    tag_q[i]  <= tag_from_fifo;
                end else if (cdb_valid && pend_q[i] && tag_q[i] == cdb_tag) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // in-flight count, saturating at both ends
    always_comb begin
        inflight_d = inflight_q;
        case ({alloc_done, tag_push_q})
            2'b10:   if (inflight_q != CNT_MAX) inflight_d = inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0)      inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // registered tag return, counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_push_q    <= 1'b0;
            tag_to_fifo_q <= '0;
            inflight_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            tag_push_q    <= cdb_valid;
            tag_to_fifo_q <= cdb_valid ? cdb_tag : '0;
            inflight_q    <= inflight_d;
            if (tag_push_q && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign tag_push     = tag_push_q;
    assign tag_to_fifo  = tag_to_fifo_q;
    assign inflight_cnt = inflight_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_reg_status_table.sv
// tb/tb_reg_status_table.sv - directed self-checking bench for reg_status_table
module tb_reg_status_table;

    logic       clk;
    logic       rst;
    logic       disp_valid;
    logic       disp_rd_we;
    logic [4:0] disp_rd;
    logic [4:0] disp_rs1;
    logic [4:0] disp_rs2;
    logic       disp_ready;
    logic       disp_done;
    logic [5:0] disp_rd_tag;
    logic       rs1_pend;
    logic [5:0] rs1_tag;
    logic       rs2_pend;
    logic [5:0] rs2_tag;
    logic       tag_pull;
    logic [5:0] tag_from_fifo;
    logic       fifo_empty;
    logic       fifo_full;
    logic       cdb_valid;
    logic [5:0] cdb_tag;
    logic       tag_push;
    logic [5:0] tag_to_fifo;
    logic [6:0] inflight_cnt;
    logic       overflow_err;

    int total;
    int bad;

    reg_status_table dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_rd_we   (disp_rd_we),
        .disp_rd      (disp_rd),
        .disp_rs1     (disp_rs1),
        .disp_rs2     (disp_rs2),
        .disp_ready   (disp_ready),
        .disp_done    (disp_done),
        .disp_rd_tag  (disp_rd_tag),
        .rs1_pend     (rs1_pend),
        .rs1_tag      (rs1_tag),
        .rs2_pend     (rs2_pend),
        .rs2_tag      (rs2_tag),
        .tag_pull     (tag_pull),
        .tag_from_fifo(tag_from_fifo),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .tag_push     (tag_push),
        .tag_to_fifo  (tag_to_fifo),
        .inflight_cnt (inflight_cnt),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        disp_valid = v;
        disp_rd_we = we;
        disp_rd    = rd;
        disp_rs1   = rs1;
        disp_rs2   = rs2;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        tag_from_fifo = '0;
        fifo_empty = 1'b0;
        fifo_full = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_done", disp_done, 0);
        chk("rst_pull", tag_pull, 0);
        chk("rst_push", tag_push, 0);
        chk("rst_cnt", inflight_cnt, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_ready", disp_ready, 1);
        drive(1, 0, 0, 5, 7);
        chk("rst_rs_done", disp_done, 1);
        chk("rst_rs1_pend", rs1_pend, 0);
        chk("rst_rs2_pend", rs2_pend, 0);
        step();

        // allocate rd=5 with tag 0x2A
        tag_from_fifo = 6'h2A;
        drive(1, 1, 5, 0, 0);
        chk("a5_pull", tag_pull, 1);
        chk("a5_done0", disp_done, 0);
        step();
        chk("a5_pull1", tag_pull, 0);
        chk("a5_done1", disp_done, 1);
        chk("a5_tag", disp_rd_tag, 6'h2A);
        chk("a5_ready_wait", disp_ready, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("a5_cnt", inflight_cnt, 1);
        chk("a5_tag_idle", disp_rd_tag, 0);
        drive(1, 0, 0, 5, 0);
        chk("r5_pend", rs1_pend, 1);
        chk("r5_tag", rs1_tag, 6'h2A);

        // CDB broadcast of 0x2A with bypass while reading rs1=5
        cdb_valid = 1'b1;
        cdb_tag = 6'h2A;
        #1;
        chk("byp_pend", rs1_pend, 0);
        chk("byp_tag", rs1_tag, 0);
        step();
        cdb_valid = 1'b0;
        #1;
        chk("cdb_push", tag_push, 1);
        chk("cdb_push_tag", tag_to_fifo, 6'h2A);
        chk("cdb_cleared", rs1_pend, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("cdb_cnt", inflight_cnt, 0);
        chk("cdb_push_off", tag_push, 0);

        // stall on empty free list
        fifo_empty = 1'b1;
        tag_from_fifo = 6'h05;
        drive(1, 1, 7, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", disp_ready, 0);
            chk("stall_pull", tag_pull, 0);
            chk("stall_done", disp_done, 0);
            step();
        end
        fifo_empty = 1'b0;
        #1;
        chk("unstall_pull", tag_pull, 1);
        step();
        chk("unstall_done", disp_done, 1);
        chk("unstall_tag", disp_rd_tag, 6'h05);
        step();
        drive(0, 0, 0, 0, 0);
        chk("unstall_cnt", inflight_cnt, 1);

        // rd=3 first producer 0x10
        tag_from_fifo = 6'h10;
        drive(1, 1, 3, 0, 0);
        step();
        chk("a3_done", disp_done, 1);
        step();
        // rd=rs1=3, new tag 0x11, rs2=7 still pending on 0x05
        tag_from_fifo = 6'h11;
        drive(1, 1, 3, 3, 7);
        chk("rr_pull", tag_pull, 1);
        step();
        chk("rr_done", disp_done, 1);
        chk("rr_rs1_pend", rs1_pend, 1);
        chk("rr_rs1_tag", rs1_tag, 6'h10);
        chk("rr_rs2_tag", rs2_tag, 6'h05);
        chk("rr_rd_tag", disp_rd_tag, 6'h11);
        cdb_valid = 1'b1;
        cdb_tag = 6'h10;
        #1;
        chk("rr_byp", rs1_pend, 0);
        step();
        cdb_valid = 1'b0;
        drive(1, 0, 0, 3, 0);
        chk("rr_push", tag_push, 1);
        chk("rr_push_tag", tag_to_fifo, 6'h10);
        chk("rr_new_pend", rs1_pend, 1);
        chk("rr_new_tag", rs1_tag, 6'h11);
        chk("rr_cnt_mid", inflight_cnt, 3);
        step();
        chk("rr_cnt", inflight_cnt, 2);

        // rd=0 completes immediately with no pull
        drive(1, 1, 0, 0, 0);
        chk("r0_done", disp_done, 1);
        chk("r0_pull", tag_pull, 0);
        chk("r0_tag", disp_rd_tag, 0);
        chk("r0_ready", disp_ready, 1);
        step();
        drive(0, 0, 0, 0, 0);

        // push while free list full
        fifo_full = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag = 6'h05;
        step();
        cdb_valid = 1'b0;
        #1;
        chk("ovf_push", tag_push, 1);
        chk("ovf_pre", overflow_err, 0);
        step();
        fifo_full = 1'b0;
        #1;
        chk("ovf_set", overflow_err, 1);
        chk("ovf_cnt", inflight_cnt, 1);
        step();
        step();
        chk("ovf_sticky", overflow_err, 1);

        // reset in WAIT abandons the allocation
        tag_from_fifo = 6'h3F;
        drive(1, 1, 9, 0, 0);
        step();
        chk("rw_wait_done", disp_done, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("rw_done", disp_done, 0);
        chk("rw_ovf", overflow_err, 0);
        chk("rw_cnt", inflight_cnt, 0);
        chk("rw_ready", disp_ready, 1);
        drive(1, 0, 0, 9, 3);
        chk("rw_rs1_pend", rs1_pend, 0);
        chk("rw_rs2_pend", rs2_pend, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("rw_cnt_after", inflight_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
